// File: rtl/confreg_scan_pkg.sv
// confreg_scan_pkg
//   Shared definitions for the conf-bus LED / 7-segment peripheral:
//   register word offsets, CTRL bit positions and the 7-segment code table.
package confreg_scan_pkg;

  // Word offset of each register, taken from conf_addr[4:2]
  typedef enum logic [2:0] {
    REG_LED   = 3'd0,
    REG_SEG   = 3'd1,
    REG_TIMER = 3'd2,
    REG_CTRL  = 3'd3,
    REG_SW    = 3'd4
  } reg_sel_e;

  localparam int unsigned CTRL_SCAN_EN_BIT = 0;
  localparam int unsigned CTRL_BLANK_LSB   = 8;
  localparam logic [31:0] CTRL_RESET       = 32'h0000_0001;

  // Active-low {g,f,e,d,c,b,a} pattern for each hex value
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
  };

endpackage

// File: rtl/confreg_scan_seg7_hex_dec.sv
// seg7_hex_dec
//   Combinational 4-bit hex to 7-segment decoder, active-low outputs.
//   hex : nibble to display
//   seg : {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_hex_dec
  import confreg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_TABLE[hex];
  end

endmodule

// File: rtl/confreg_scan.sv
// confreg_scan
//   Memory-mapped config peripheral: LED register, multiplexed 7-segment
//   display, free-running timer and synchronised switch inputs.
//   clk, reset      : rising-edge clock, synchronous active-low reset
//   conf_*          : CPU conf bus (byte write enables, registered 1-cycle read)
//   sw              : raw asynchronous switches
//   led             : LED drive, active-high
//   seg_an, seg_cat : digit enables / cathodes {dp,g..a}, both active-low
module confreg_scan
  import confreg_scan_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hffff0000,
  parameter int unsigned LED_W      = 16,
  parameter int unsigned SEG_DIGITS = 4,
  parameter int unsigned SW_W       = 8,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  conf_en,
  input  logic [3:0]            conf_wen,
  input  logic [31:0]           conf_addr,
  input  logic [31:0]           conf_wdata,
  output logic [31:0]           conf_rdata,
  input  logic [SW_W-1:0]       sw,
  output logic [LED_W-1:0]      led,
  output logic [SEG_DIGITS-1:0] seg_an,
  output logic [7:0]            seg_cat
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (SEG_DIGITS > 1) ? $clog2(SEG_DIGITS) : 1;

  localparam logic [31:0] LED_MASK = (LED_W >= 32) ? '1 : ((32'h1 << LED_W) - 32'h1);
  localparam logic [31:0] SEG_MASK = (SEG_DIGITS >= 8) ? '1 : ((32'h1 << (4 * SEG_DIGITS)) - 32'h1);
  localparam logic [31:0] CTRL_MASK = 32'h1 | (((32'h1 << SEG_DIGITS) - 32'h1) << CTRL_BLANK_LSB);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int unsigned b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0]     led_q, seg_q, timer_q, ctrl_q;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;

  logic        hit, wr;
  logic [2:0]  sel;
  logic [31:0] rd_val;

  assign sel = conf_addr[4:2];
  assign hit = (conf_addr[31:5] == BASE_ADDR[31:5]) && (conf_addr[1:0] == 2'b00);
  assign wr  = conf_en && (|conf_wen) && hit;

  // Register file; masks keep unimplemented bits at zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q   <= '0;
      seg_q   <= '0;
      timer_q <= '0;
      ctrl_q  <= CTRL_RESET;
    end else begin
      if (wr && sel == REG_LED)  led_q  <= byte_merge(led_q, conf_wdata, conf_wen) & LED_MASK;
      if (wr && sel == REG_SEG)  seg_q  <= byte_merge(seg_q, conf_wdata, conf_wen) & SEG_MASK;
      if (wr && sel == REG_CTRL) ctrl_q <= byte_merge(ctrl_q, conf_wdata, conf_wen) & CTRL_MASK;
      // A timer write replaces the increment for that cycle
      if (wr && sel == REG_TIMER) timer_q <= byte_merge(timer_q, conf_wdata, conf_wen);
      else                        timer_q <= timer_q + 32'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (sel)
        REG_LED:   rd_val = led_q;
        REG_SEG:   rd_val = seg_q;
        REG_TIMER: rd_val = timer_q;
        REG_CTRL:  rd_val = ctrl_q;
        REG_SW:    rd_val = 32'(sw_s2);
        default:   rd_val = '0;
      endcase
    end
  end

  // Read data captures pre-write register values
  always_ff @(posedge clk) begin
    if (!reset)       conf_rdata <= '0;
    else if (conf_en) conf_rdata <= rd_val;
  end

  assign led = led_q[LED_W-1:0];

  // Display scan
  logic                  scan_en;
  logic [SEG_DIGITS-1:0] blank_vec;
  logic [3:0]            nib;
  logic [6:0]            seg_code;

  assign scan_en   = ctrl_q[CTRL_SCAN_EN_BIT];
  assign blank_vec = ctrl_q[CTRL_BLANK_LSB +: SEG_DIGITS];
  assign nib       = 4'(seg_q >> {idx_q, 2'b00});

  seg7_hex_dec u_dec (
    .hex (nib),
    .seg (seg_code)
  );

  always_ff @(posedge clk) begin
    if (!reset || !scan_en) begin
      div_q   <= '0;
      idx_q   <= '0;
      seg_an  <= '1;
      seg_cat <= '1;
    end else begin
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= (idx_q == IDX_W'(SEG_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (blank_vec[idx_q]) begin
        seg_an  <= '1;
        seg_cat <= '1;
      end else begin
        seg_an  <= ~(SEG_DIGITS'(1) << idx_q);
        seg_cat <= {1'b1, seg_code};
      end
    end
  end

endmodule

// File: tb/tb_confreg_scan.sv
// tb_confreg_scan
//   Directed self-checking bench for confreg_scan with SCAN_DIV = 4.
module tb_confreg_scan;

  localparam logic [31:0] BASE = 32'hffff0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic [3:0]  seg_an;
  logic [7:0]  seg_cat;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  confreg_scan #(
    .BASE_ADDR  (BASE),
    .LED_W      (16),
    .SEG_DIGITS (4),
    .SW_W       (8),
    .SCAN_DIV   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .conf_en    (conf_en),
    .conf_wen   (conf_wen),
    .conf_addr  (conf_addr),
    .conf_wdata (conf_wdata),
    .conf_rdata (conf_rdata),
    .sw         (sw),
    .led        (led),
    .seg_an     (seg_an),
    .seg_cat    (seg_cat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    conf_en = 1'b1; conf_wen = we; conf_addr = a; conf_wdata = d;
    tick();
    conf_en = 1'b0; conf_wen = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    conf_en = 1'b1; conf_wen = 4'h0; conf_addr = a;
    tick();
    conf_en = 1'b0;
    d = conf_rdata;
  endtask

  logic [7:0] cat_exp [4] = '{8'hf9, 8'ha4, 8'hb0, 8'h99};
  logic [31:0] rd;
  logic [3:0]  an_exp;

  initial begin
    reset = 1'b0; conf_en = 1'b0; conf_wen = 4'h0; conf_addr = '0; conf_wdata = '0; sw = 8'h00;
    repeat (3) tick();
    check_eq("rst_led", 32'(led), 32'h0);
    check_eq("rst_an", 32'(seg_an), 32'hf);
    check_eq("rst_cat", 32'(seg_cat), 32'hff);
    check_eq("rst_rdata", conf_rdata, 32'h0);

    // First digit appears one cycle after release (SEG_DATA = 0 -> '0' glyph)
    reset = 1'b1;
    tick();
    check_eq("first_an", 32'(seg_an), 32'he);
    check_eq("first_cat", 32'(seg_cat), 32'hc0);

    bus_read(BASE + 32'h0c, rd);
    check_eq("ctrl_rst", rd, 32'h1);

    // LED byte-enable writes and width masking
    bus_write(BASE + 32'h00, 32'h0000a5a5, 4'b0001);
    check_eq("led_b0", 32'(led), 32'h00a5);
    bus_read(BASE + 32'h00, rd);
    check_eq("led_rd", rd, 32'h000000a5);
    bus_write(BASE + 32'h00, 32'h12345678, 4'b1111);
    bus_read(BASE + 32'h00, rd);
    check_eq("led_mask", rd, 32'h00005678);

    // Same-cycle write + read returns the old value
    conf_en = 1'b1; conf_wen = 4'hf; conf_addr = BASE; conf_wdata = 32'h0000ffff;
    tick();
    conf_en = 1'b0; conf_wen = 4'h0;
    check_eq("rw_old", conf_rdata, 32'h00005678);
    check_eq("rw_led", 32'(led), 32'hffff);

    // Decode misses
    bus_write(BASE + 32'h02, 32'h0, 4'hf);
    check_eq("miss_wr", 32'(led), 32'hffff);
    bus_read(BASE + 32'h14, rd);
    check_eq("miss_14", rd, 32'h0);
    bus_read(BASE + 32'h02, rd);
    check_eq("miss_unal", rd, 32'h0);
    bus_read(32'hfffe0000, rd);
    check_eq("miss_base", rd, 32'h0);

    // Timer load and wrap
    bus_write(BASE + 32'h08, 32'hfffffffe, 4'hf);
    bus_read(BASE + 32'h08, rd);
    check_eq("tmr_0", rd, 32'hfffffffe);
    bus_read(BASE + 32'h08, rd);
    check_eq("tmr_1", rd, 32'hffffffff);
    bus_read(BASE + 32'h08, rd);
    check_eq("tmr_wrap", rd, 32'h0);

    // Scan sequence: CTRL 0 then 1 aligns the scan to digit 0, div 0
    bus_write(BASE + 32'h04, 32'h00004321, 4'hf);
    bus_read(BASE + 32'h04, rd);
    check_eq("seg_rd", rd, 32'h00004321);
    bus_write(BASE + 32'h0c, 32'h0, 4'hf);
    bus_write(BASE + 32'h0c, 32'h1, 4'hf);
    check_eq("off_an", 32'(seg_an), 32'hf);
    check_eq("off_cat", 32'(seg_cat), 32'hff);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        an_exp = ~(4'b0001 << (k % 4));
        check_eq($sformatf("scan_an_%0d_%0d", k, c), 32'(seg_an), 32'(an_exp));
        check_eq($sformatf("scan_cat_%0d_%0d", k, c), 32'(seg_cat), 32'(cat_exp[k % 4]));
      end
    end

    // Digit 1 blanked
    bus_write(BASE + 32'h0c, 32'h0, 4'hf);
    bus_write(BASE + 32'h0c, 32'h201, 4'hf);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        if (c == 0) begin
          an_exp = (k == 1) ? 4'hf : ~(4'b0001 << k);
          check_eq($sformatf("blk_an_%0d", k), 32'(seg_an), 32'(an_exp));
          check_eq($sformatf("blk_cat_%0d", k), 32'(seg_cat), (k == 1) ? 32'hff : 32'(cat_exp[k]));
        end
      end
    end

    // Mid-digit disable then re-enable restarts at digit 0 with div 0
    tick();
    bus_write(BASE + 32'h0c, 32'h0, 4'hf);
    tick();
    check_eq("clr_an", 32'(seg_an), 32'hf);
    check_eq("clr_cat", 32'(seg_cat), 32'hff);
    bus_write(BASE + 32'h0c, 32'h1, 4'hf);
    tick();
    check_eq("re_an", 32'(seg_an), 32'he);
    check_eq("re_cat", 32'(seg_cat), 32'hf9);
    repeat (3) tick();
    check_eq("re_an_last", 32'(seg_an), 32'he);
    tick();
    check_eq("re_an_d1", 32'(seg_an), 32'hd);

    // Switch synchroniser and read-only SW register
    sw = 8'h3c;
    repeat (2) tick();
    bus_read(BASE + 32'h10, rd);
    check_eq("sw_rd", rd, 32'h3c);
    bus_write(BASE + 32'h10, 32'hffffffff, 4'hf);
    bus_read(BASE + 32'h10, rd);
    check_eq("sw_ro", rd, 32'h3c);

    // Reset during scan
    bus_write(BASE + 32'h00, 32'h0000beef, 4'hf);
    bus_write(BASE + 32'h0c, 32'h301, 4'hf);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_eq("mid_rst_led", 32'(led), 32'h0);
    check_eq("mid_rst_an", 32'(seg_an), 32'hf);
    check_eq("mid_rst_cat", 32'(seg_cat), 32'hff);
    reset = 1'b1;
    bus_read(BASE + 32'h08, rd);
    check_eq("mid_rst_tmr", rd, 32'h0);
    bus_read(BASE + 32'h0c, rd);
    check_eq("mid_rst_ctrl", rd, 32'h1);
    bus_read(BASE + 32'h04, rd);
    check_eq("mid_rst_seg", rd, 32'h0);
    bus_read(BASE + 32'h10, rd);
    check_eq("mid_rst_sw", rd, 32'h3c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
